// File: rtl/regs_scoreboard.sv
// -----------------------------------------------------------------------------
// regs_scoreboard
//   Writer-side hazard tracker for the architectural register file. It keeps
//   one small counter per register of long-latency writes (loads, mul/div)
//   still in flight, plus a global in-flight count. Issue marks a destination
//   pending and writeback retires it. Decode-stage readers query pending
//   status and receive a stall request. Register 0 is never tracked.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   flush_i          drop all outstanding tracking (error flag is kept)
//   issue_valid_i    long-latency write to issue_waddr_i is issuing
//   issue_waddr_i    destination register of the issuing op
//   issue_ready_o    issue accepted (combinational)
//   retire_valid_i   writeback of a tracked op
//   retire_waddr_i   destination register being written back
//   regs_raddr_i     READ_PORTS register addresses queried by decode
//   pending_o        per-port pending flag (from registered state only)
//   stall_o          OR of pending_o
//   busy_o           any write in flight
//   inflight_o       global in-flight count
//   err_o            sticky protocol error (retire with nothing outstanding)
// -----------------------------------------------------------------------------
module regs_scoreboard #(
  parameter  int REG_NUM     = 32,
  parameter  int READ_PORTS  = 2,
  parameter  int CNT_WIDTH   = 2,
  parameter  int TOTAL_WIDTH = 4,
  localparam int AW          = $clog2(REG_NUM)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic                            issue_valid_i,
  input  logic [AW-1:0]                   issue_waddr_i,
  output logic                            issue_ready_o,
  input  logic                            retire_valid_i,
  input  logic [AW-1:0]                   retire_waddr_i,
  input  logic [READ_PORTS-1:0][AW-1:0]   regs_raddr_i,
  output logic [READ_PORTS-1:0]           pending_o,
  output logic                            stall_o,
  output logic                            busy_o,
  output logic [TOTAL_WIDTH-1:0]          inflight_o,
  output logic                            err_o
);

  localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [TOTAL_WIDTH-1:0] TOTAL_MAX = '1;
  localparam logic [TOTAL_WIDTH-1:0] TOTAL_ONE = TOTAL_WIDTH'(1);

  logic [CNT_WIDTH-1:0]   cnt_q [REG_NUM];
  logic [CNT_WIDTH-1:0]   cnt_d [REG_NUM];
  logic [TOTAL_WIDTH-1:0] total_q, total_d;
  logic                   err_q, err_d;

  logic issue_nz, retire_nz;
  logic retire_same_reg;
  logic retire_dec;     // retire that really decrements a counter this cycle
  logic underflow;
  logic issue_ready;
  logic issue_fire;

  // ---------------------------------------------------------------------------
  // Handshake and event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the block leaves it unassigned (no latch).
    issue_nz        = (issue_waddr_i != '0);
    retire_nz       = (retire_waddr_i != '0);
    retire_same_reg = retire_valid_i && (retire_waddr_i == issue_waddr_i);

    underflow  = retire_valid_i && !flush_i && retire_nz &&
                 (cnt_q[retire_waddr_i] == '0);
    // A retire frees a global slot only when it actually decrements; a retire
    // to r0 or an underflowing retire must not let total wrap past its max.
    retire_dec = retire_valid_i && retire_nz &&
                 (cnt_q[retire_waddr_i] != '0);

    issue_ready = 1'b1;
    if (issue_nz) begin
      if ((cnt_q[issue_waddr_i] == CNT_MAX) && !retire_same_reg) issue_ready = 1'b0;
      if ((total_q == TOTAL_MAX) && !retire_dec)                  issue_ready = 1'b0;
    end

    // r0 issues are accepted but never tracked.
    issue_fire = issue_valid_i && issue_ready && !flush_i && issue_nz;
  end

  assign issue_ready_o = issue_ready;

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    logic inc, dec, dec_fire;
    dec_fire = retire_dec && !flush_i;

    for (int i = 0; i < REG_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      inc = issue_fire && (issue_waddr_i == AW'(i));
      dec = dec_fire   && (retire_waddr_i == AW'(i));
      if (inc && !dec)      cnt_d[i] = cnt_q[i] + CNT_ONE;
      else if (dec && !inc) cnt_d[i] = cnt_q[i] - CNT_ONE;
    end

    total_d = total_q;
    if (issue_fire && !dec_fire)      total_d = total_q + TOTAL_ONE;
    else if (dec_fire && !issue_fire) total_d = total_q - TOTAL_ONE;

    err_d = err_q | underflow;

    if (flush_i) begin
      for (int i = 0; i < REG_NUM; i++) cnt_d[i] = '0;
      total_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the counter array is a bank of flops, not a RAM, so it can and must
  // be cleared by the asynchronous reset along with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of statement order.
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) cnt_q[i] <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) cnt_q[i] <= cnt_d[i];
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Query side: registered state only, so a same-cycle retire still reports
  // pending (decode forwarding covers the writeback cycle).
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      pending_o[p] = (regs_raddr_i[p] != '0) && (cnt_q[regs_raddr_i[p]] != '0);
    end
  end

  assign stall_o    = |pending_o;
  assign busy_o     = (total_q != '0);
  assign inflight_o = total_q;
  assign err_o      = err_q;

endmodule

// File: doc/regs_scoreboard.md
Name: regs_scoreboard

Overview:
- Writer-side hazard tracker for the register file. Counts in-flight writes per architectural register for long-latency producers (loads, mul/div).
- Issue logic marks a destination register as pending; writeback retires it.
- Decode-stage readers query pending status and get a stall request. This is the producer-side complement to the decode-stage forward/stall logic.

Parameters:
- REG_NUM, 32, number of architectural registers (address width = $clog2(REG_NUM)).
- READ_PORTS, 2, number of concurrent pending queries.
- CNT_WIDTH, 2, per-register in-flight counter width (max 2^CNT_WIDTH-1 outstanding writes per register).
- TOTAL_WIDTH, 4, width of global in-flight counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  pipeline flush; drops all outstanding tracking.
- issue_valid_i  input  1  a long-latency write to issue_waddr_i is issuing this cycle.
- issue_waddr_i  input  5  destination register of the issuing op.
- issue_ready_o  output  1  issue accepted (handshake with issue_valid_i).
- retire_valid_i  input  1  writeback of a tracked op this cycle.
- retire_waddr_i  input  5  destination register being written back.
- regs_raddr_i  input  READ_PORTS x 5  registers read by the decode stage.
- pending_o  output  READ_PORTS  per-port pending flag.
- stall_o  output  1  OR of pending_o.
- busy_o  output  1  any write in flight (global count != 0).
- inflight_o  output  TOTAL_WIDTH  global in-flight count.
- err_o  output  1  sticky protocol error.

Behaviour:
- State: cnt[REG_NUM] of CNT_WIDTH bits, total of TOTAL_WIDTH bits, err flag.
- Reset (async, rst_n=0): all cnt=0, total=0, err=0. The outputs are then pending_o=0, stall_o=0, busy_o=0, inflight_o=0, err_o=0, and issue_ready_o=1.
- Register 0 is never tracked:
  - Issue to r0 is accepted (ready=1) with no state change.
  - Retire to r0 is a no-op.
  - A query of r0 returns pending=0.
- issue_ready_o is combinational. It is 0 when issue_waddr_i!=0 and either of these holds:
  - cnt[issue_waddr_i] is at max and no same-register retire is occurring this cycle.
  - total is at max and no retire is occurring this cycle.
  - Otherwise issue_ready_o=1.
- Issue fires when issue_valid_i && issue_ready_o && !flush_i.
- Retire fires when retire_valid_i && !flush_i.
- Per-register update (next-cycle):
  - cnt += issue_fire(addr) − retire_fire(addr).
  - Simultaneous issue and retire to the same register leaves cnt unchanged.
  - Issue and retire to different registers update both.
- Total update: total += issue_fire(nonzero) − retire_fire(nonzero).
- Underflow: a retire to a register with cnt==0 leaves cnt and total unchanged and sets err (sticky until reset).
- Flush: next cycle all cnt=0 and total=0. Issue and retire in the flush cycle are ignored. err is not cleared.
- pending_o[i] = (regs_raddr_i[i]!=0) && (cnt[regs_raddr_i[i]]!=0).
  - It is combinational from registered state only.
  - A same-cycle retire does not clear pending in that cycle; the decode forwarding path covers the writeback cycle.
  - A same-cycle issue does not set pending until the next cycle.
- busy_o = (total!=0). inflight_o = total.
- Latency: issue is visible on pending_o 1 cycle after the issue edge; retire clears it 1 cycle after the retire edge.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

Test Plan:
- Reset: rst_n=0 with pending inputs driven -> all outputs 0, issue_ready_o=1; release, idle 5 cycles -> unchanged.
- Basic: issue r5 at cycle 0; query r5 -> pending_o[0]=0 in cycle 0 and =1 from cycle 1, inflight_o=1. Retire r5 at cycle 3 -> pending=1 in cycle 3, =0 in cycle 4, busy_o=0.
- Saturation (CNT_WIDTH=2): issue r7 three times -> cnt=3. A 4th issue sees issue_ready_o=0 and is not counted. The 4th issue with a simultaneous retire of r7 -> ready=1 and cnt stays 3.
- Simultaneous events:
  - Issue r3 plus retire r3 (cnt=1) -> cnt stays 1, inflight unchanged.
  - Issue r4 plus retire r3 -> r4 pending, r3 clear, inflight unchanged.
- Flush: 3 registers pending, inflight=3; flush_i=1 with concurrent issue r9 -> next cycle all pending=0, inflight=0, r9 not pending.
- r0 and underflow:
  - Issue r0 -> ready=1, inflight stays 0.
  - Retire r10 with cnt=0 -> err_o=1 next cycle and stays 1 through a subsequent flush; cleared only by rst_n=0.
